// File: rtl/tt_adj_builder.sv
// Frame capture front-end: beat 0 latches the query and later beats set adjacency bits.
// Define TT_DIRECTED_EN to record one-way tracks (only M[a][b]).
module tt_adj_builder #(
   parameter  int N_ST  = 16,
   parameter  int CNT_W = 8,
   localparam int ID_W  = $clog2(N_ST)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [ID_W-1:0]  source,
   input  logic [ID_W-1:0]  destination,
   output logic             graph_valid,
   input  logic             graph_ack,
   output logic [ID_W-1:0]  q_src,
   output logic [ID_W-1:0]  q_dst,
   input  logic [ID_W-1:0]  rd_addr,
   output logic [N_ST-1:0]  rd_row,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             overrun
);

   typedef enum logic [1:0] {IDLE, COLLECT, READY} state_t;

   state_t                     state, state_nxt;
   logic                       beat0, trk_we, set_ovr;
   logic [N_ST-1:0][N_ST-1:0]  mat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A beat in READY is a new frame regardless of ack; missing ack marks overrun.
   always_comb begin
      state_nxt = state;
      beat0     = 1'b0;
      trk_we    = 1'b0;
      set_ovr   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               beat0     = 1'b1;
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) trk_we    = 1'b1;
            else          state_nxt = READY;
         end
         READY: begin
            if (in_valid) begin
               beat0     = 1'b1;
               set_ovr   = !graph_ack;
               state_nxt = COLLECT;
            end else if (graph_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mat      <= '0;
         q_src    <= '0;
         q_dst    <= '0;
         edge_cnt <= '0;
         overrun  <= 1'b0;
      end else begin
         if (beat0) begin
            q_src    <= source;
            q_dst    <= destination;
            mat      <= '0;
            edge_cnt <= '0;
         end else if (trk_we && (source != destination)) begin
            mat[source][destination] <= 1'b1;
`ifndef TT_DIRECTED_EN
            mat[destination][source] <= 1'b1;
`endif
            if (edge_cnt != {CNT_W{1'b1}}) edge_cnt <= edge_cnt + CNT_W'(1);
         end
         if (set_ovr) overrun <= 1'b1;
      end
   end

   assign graph_valid = (state == READY);
   assign rd_row      = mat[rd_addr];

endmodule

// File: tb/tb_tt_adj_builder.sv
// Scoreboard bench for tt_adj_builder: random frames vs. a set-based adjacency model.
// Honours TT_DIRECTED_EN the same way as the design.
module tb_tt_adj_builder;

   logic        clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, graph_ack = 1'b0;
   logic [3:0]  source = '0, destination = '0, rd_addr = '0;
   logic        graph_valid, overrun;
   logic [3:0]  q_src, q_dst;
   logic [15:0] rd_row;
   logic [7:0]  edge_cnt;

   tt_adj_builder #(.N_ST(16), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .source(source),
      .destination(destination), .graph_valid(graph_valid), .graph_ack(graph_ack),
      .q_src(q_src), .q_dst(q_dst), .rd_addr(rd_addr), .rd_row(rd_row),
      .edge_cnt(edge_cnt), .overrun(overrun)
   );

   always #50 if (clk_en) clk = ~clk;

   typedef struct packed {
      logic [3:0]         qs;
      logic [3:0]         qd;
      logic [15:0][15:0]  m;
      logic [7:0]         cnt;
      logic               ovr;
   } exp_t;

   exp_t               sb[$];
   exp_t               cur;
   int                 trk_a[$], trk_b[$];
   int                 errors = 0, checks = 0;
   int                 scan_req = 0;
   logic [15:0][15:0]  exp_scan = '0;
   bit                 model_ready = 0, model_ovr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected matrix straight from the track list: a set of (a,b) pairs, self-loops dropped.
   function automatic logic [15:0][15:0] ref_matrix();
      logic [15:0][15:0] m = '0;
      for (int i = 0; i < trk_a.size(); i++)
         if (trk_a[i] != trk_b[i]) begin
            m[trk_a[i]][trk_b[i]] = 1'b1;
`ifndef TT_DIRECTED_EN
            m[trk_b[i]][trk_a[i]] = 1'b1;
`endif
         end
      return m;
   endfunction

   function automatic logic [7:0] ref_count();
      int n = 0;
      for (int i = 0; i < trk_a.size(); i++) if (trk_a[i] != trk_b[i]) n++;
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   task automatic scan_rows(input logic [15:0][15:0] m, input string tag);
      for (int r = 0; r < 16; r++) begin
         rd_addr = 4'(r);
         #1;
         chk($sformatf("%s_row%0d", tag, r), 32'(rd_row), 32'(m[r]));
      end
   endtask

   // Monitor: owns rd_addr; checks every new graph_valid and any explicit scan request.
   initial begin
      bit   prev = 0;
      int   scans_done = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (scan_req != scans_done) begin
            scan_rows(exp_scan, "scan");
            scans_done++;
         end
         if (graph_valid && !prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame", 32'(graph_valid), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("mon_q_src", 32'(q_src), 32'(e.qs));
               chk("mon_q_dst", 32'(q_dst), 32'(e.qd));
               chk("mon_edge_cnt", 32'(edge_cnt), 32'(e.cnt));
               chk("mon_overrun", 32'(overrun), 32'(e.ovr));
               scan_rows(e.m, "frame");
            end
         end
         prev = graph_valid;
      end
   end

   task automatic request_scan(input logic [15:0][15:0] m);
      exp_scan = m;
      scan_req++;
      repeat (2) @(posedge clk);
   endtask

   task automatic run_frame(input logic [3:0] qs, input logic [3:0] qd, input bit ack0);
      exp_t e;
      @(posedge clk); #1;
      if (model_ready && !ack0) model_ovr = 1;
      in_valid = 1'b1; source = qs; destination = qd; graph_ack = ack0;
      @(posedge clk); #1;
      graph_ack = 1'b0;
      model_ready = 0;
      chk("beat0_gv", 32'(graph_valid), 32'(0));
      chk("beat0_cnt", 32'(edge_cnt), 32'(0));
      chk("beat0_q_src", 32'(q_src), 32'(qs));
      chk("beat0_overrun", 32'(overrun), 32'(model_ovr));
      for (int i = 0; i < trk_a.size(); i++) begin
         source = 4'(trk_a[i]); destination = 4'(trk_b[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; source = 4'($urandom); destination = 4'($urandom);
      e.qs = qs; e.qd = qd; e.m = ref_matrix(); e.cnt = ref_count(); e.ovr = model_ovr;
      sb.push_back(e);
      cur = e;
      @(posedge clk); #1;
      chk("latency_gv", 32'(graph_valid), 32'(1));
      model_ready = 1;
   endtask

   task automatic do_ack();
      @(posedge clk); #1;
      graph_ack = 1'b1;
      @(posedge clk); #1;
      graph_ack = 1'b0;
      model_ready = 0;
      chk("ack_gv", 32'(graph_valid), 32'(0));
      chk("ack_q_src", 32'(q_src), 32'(cur.qs));
      chk("ack_q_dst", 32'(q_dst), 32'(cur.qd));
      request_scan(cur.m);
   endtask

   task automatic rand_tracks(input int n);
      trk_a.delete(); trk_b.delete();
      for (int i = 0; i < n; i++) begin
         trk_a.push_back($urandom_range(15));
         trk_b.push_back(($urandom_range(7) == 0) ? trk_a[i] : int'($urandom_range(15)));
      end
   endtask

   initial begin
      logic [15:0][15:0] t2;
      int act, prev_act;

      // Reset with the clock held low
      #20;
      chk("rst_gv", 32'(graph_valid), 32'(0));
      chk("rst_q_src", 32'(q_src), 32'(0));
      chk("rst_q_dst", 32'(q_dst), 32'(0));
      chk("rst_cnt", 32'(edge_cnt), 32'(0));
      chk("rst_overrun", 32'(overrun), 32'(0));
      rst_n = 1'b1;
      #10 clk_en = 1'b1;
      request_scan('0);

      // Known frame with fixed expected rows
      trk_a = '{0, 3}; trk_b = '{3, 15};
      run_frame(4'd0, 4'd15, 1'b0);
      t2 = '0;
`ifdef TT_DIRECTED_EN
      t2[0] = 16'h0008; t2[3] = 16'h8000;
`else
      t2[0] = 16'h0008; t2[3] = 16'h8001; t2[15] = 16'h0008;
`endif
      chk("t2_cnt", 32'(edge_cnt), 32'(2));
      request_scan(t2);
      do_ack();

      // Self-loop and duplicate track
      trk_a = '{5, 4, 4}; trk_b = '{5, 6, 6};
      run_frame(4'd2, 4'd9, 1'b0);
      chk("t3_cnt", 32'(edge_cnt), 32'(2));

      // Unacked new frame, query only
      trk_a.delete(); trk_b.delete();
      run_frame(4'd1, 4'd2, 1'b0);
      chk("t4_overrun", 32'(overrun), 32'(1));

      // New frame with ack on the same cycle
      rand_tracks(5);
      run_frame(4'd7, 4'd3, 1'b1);

      // Random frames with random hand-off
      prev_act = 2;
      for (int f = 0; f < 24; f++) begin
         rand_tracks($urandom_range(12));
         run_frame(4'($urandom), 4'($urandom), prev_act == 2);
         act = $urandom_range(2);
         if (act == 0) do_ack();
         prev_act = act;
      end
      do_ack();

      // Edge count saturation
      trk_a.delete(); trk_b.delete();
      for (int i = 0; i < 300; i++) begin
         trk_a.push_back(i % 16);
         trk_b.push_back((i + 1 + (i / 16) % 15) % 16);
      end
      run_frame(4'd4, 4'd11, 1'b0);
      chk("sat_cnt", 32'(edge_cnt), 32'(255));
      do_ack();

      // Reset in the middle of a frame
      @(posedge clk); #1;
      in_valid = 1'b1; source = 4'd6; destination = 4'd8;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         source = 4'(i); destination = 4'(i + 5);
      end
      @(posedge clk); #10;
      rst_n = 1'b0; in_valid = 1'b0;
      #5;
      model_ovr = 0; model_ready = 0;
      chk("mid_rst_gv", 32'(graph_valid), 32'(0));
      chk("mid_rst_cnt", 32'(edge_cnt), 32'(0));
      chk("mid_rst_q_src", 32'(q_src), 32'(0));
      chk("mid_rst_q_dst", 32'(q_dst), 32'(0));
      chk("mid_rst_overrun", 32'(overrun), 32'(0));
      #10 rst_n = 1'b1;
      request_scan('0);

      rand_tracks(6);
      run_frame(4'd9, 4'd1, 1'b0);
      do_ack();

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
